xif_mac_coprocessor: RTL and testbench
======================================

# xif_mac_coprocessor

Single-issue CORE-V-XIF v1.0 coprocessor implementing a 32-bit multiply-accumulate unit on the custom-0 opcode. It sits on the coprocessor end of the `if_xif` bundle that the CV32E20 wrapper drives, in place of or alongside other accelerators. It answers issue requests, honours commit and kill, and returns results over the result interface. It has no memory-interface usage.

## Interface
**Parameters**
- `X_ID_WIDTH`, default 4: instruction id width; must match the `if_xif` instance.
- `OPCODE`, default 7'h0B: major opcode the block decodes (custom-0).

**Ports**
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `xif_issue_if`  modport  `if_xif.coproc_issue`  issue request and response.
- `xif_commit_if`  modport  `if_xif.coproc_commit`  commit and kill.
- `xif_result_if`  modport  `if_xif.coproc_result`  writeback.
- `acc_o`  out  32  current accumulator value, for debug and observation.

## Operation
**Decode.** `instr[6:0]==OPCODE` and `instr[31:25]==0`, with `funct3 = instr[14:12]`:
- 000 MAC: `acc += rs[0]*rs[1]` (low 32 bits). rd receives the new acc.
- 001 CLR: acc becomes 0. rd receives the old acc.
- 010 RDA: rd receives acc. acc is unchanged.
- Any other encoding: `accept=0` and `writeback=0`. The block keeps no state for it.

**Issue response.**
- `accept=1` and `writeback=1` for the three valid encodings.
- The response is combinational and valid only while `issue_valid`.
- `issue_ready = (state==IDLE) && !rst_i && (funct3!=000 || &rs_valid[1:0])`.

**State machine.**
- `IDLE`
  - On an issue handshake of an accepted instruction, latch `id`, `rd = instr[11:7]`, `op`, `rs[0]` and `rs[1]`, then go to `BUSY`.
  - If `commit_valid` arrives in the same cycle with a matching id and no kill, also set `committed`.
- `BUSY`
  - On `commit_valid` with a matching id: `commit_kill=1` returns to `IDLE` next cycle, aborts the multiplier and leaves acc untouched. Otherwise set `committed`.
  - When `committed && done`, go to `RESULT`.
- `RESULT`
  - Hold `result_valid=1`, `result.id`, `result.rd`, `result.data` and `result.we = (rd!=0)` stable until `result_ready`.
  - On the handshake, update acc (MAC or CLR) and return to `IDLE`.

**Commit filtering.** Commits whose id does not match the latched id, or that arrive while in `IDLE` or `RESULT`, are ignored. These include commits for rejected instructions.

**Multiplier.** MAC is multiplied speculatively from issue. It is 32-cycle radix-2 shift-add by default; `done` rises 32 cycles after issue. For CLR and RDA, `done` is set at issue.

## Timing
- Issue handshake in cycle i, valid commit in cycle c (c ≥ i): `result_valid` first rises in cycle `max(c, i+L)+1`, where L=32 for MAC (0 with the fast-multiply macro) and L=0 for CLR/RDA.
- Back-to-back operation: the earliest next `issue_ready` is the cycle after the result handshake.
- Kill in cycle k: `issue_ready` rises in cycle k+1.
- Reset values: state `IDLE`, acc 0, `committed` 0, `done` 0, `result_valid` 0, `result.*` 0, `acc_o` 0. `issue_ready` is 0 while `rst_i` is high.
- Reset mid-operation discards the instruction with no result and clears acc.
- acc arithmetic is modulo 2^32 and overflow is silently dropped.

## Configuration
- `XIF_MAC_FAST_MUL_EN` defined:
  - The multiplier is a single-cycle combinational 32x32 multiplier, low 32 bits.
  - `done` is set at issue, so L=0 for MAC.
  - The sub-module is not instantiated.
- Undefined: the iterative 32-cycle multiplier is used (default).

## Structure
- Package `xif_mac_pkg`:
  - `OPCODE_CUSTOM0`
  - `mac_op_e` enum (`MAC`, `CLR`, `RDA`) with funct3 encodings
  - `mac_state_e` enum (`IDLE`, `BUSY`, `RESULT`)
  - `MUL_CYCLES = 32`
- One sub-module, `xif_mac_seq_mul`:
  - Inputs: `start`, `abort`, 32-bit operands.
  - Outputs: `done` and a 32-bit product.
  - Built from a 6-bit counter and shift-add.
- The top module holds the FSM, decode, commit filter, acc register and result register.

## Test plan
- Reset, then MAC with rs=3,5, commit in the same cycle → result data=15, rd as encoded, we=1. `result_valid` is at cycle i+33 (i+1 with fast). acc=15 after the handshake.
- MAC 7×6 with acc=15, commit 40 cycles after issue → `result_valid` at c+1, data=57.
- MAC with `commit_kill=1` 10 cycles after issue → no `result_valid` ever. acc is unchanged. `issue_ready` returns at k+1.
- `result_ready` held low for 5 cycles in `RESULT` → valid, id, rd and data are stable throughout. A second issue is refused (`issue_ready=0`).
- Encoding checks:
  - funct3=011 or `instr[31:25]≠0` → `accept=0`, `writeback=0`, state stays `IDLE`.
  - A stray commit with a non-matching id is ignored.
  - MAC with `rs_valid=2'b01` → `issue_ready=0`.
- CLR with acc=0xFFFF_FFFF → data=0xFFFF_FFFF, acc=0. A following RDA returns 0 one cycle after commit. A wrap check, acc 0xFFFF_FFFF plus 1×1, gives 0.

Source files
------------

// File: rtl/xif_mac_pkg.sv
// Shared types and constants for the XIF multiply-accumulate coprocessor.
package xif_mac_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
    localparam int         MUL_CYCLES     = 32;

    typedef enum logic [2:0] {
        MAC = 3'b000,
        CLR = 3'b001,
        RDA = 3'b010
    } mac_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESULT
    } mac_state_e;

    function automatic logic is_mac_instr(input logic [31:0] instr, input logic [6:0] opcode);
        logic f3_ok;
        f3_ok = (instr[14:12] == MAC) || (instr[14:12] == CLR) || (instr[14:12] == RDA);
        return (instr[6:0] == opcode) && (instr[31:25] == 7'd0) && f3_ok;
    endfunction

endpackage

// File: rtl/if_xif.sv
// Reduced CORE-V-XIF bundle: issue, commit and result channels, no memory interface.
interface if_xif #(
    parameter int X_ID_WIDTH = 4
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [1:0][31:0]      issue_rs;
    logic [1:0]            issue_rs_valid;
    logic                  issue_accept;
    logic                  issue_writeback;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [31:0]           result_data;
    logic [4:0]            result_rd;
    logic                  result_we;

    modport coproc_issue (
        input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        output issue_ready, issue_accept, issue_writeback
    );
    modport coproc_commit (
        input  commit_valid, commit_id, commit_kill
    );
    modport coproc_result (
        input  result_ready,
        output result_valid, result_id, result_data, result_rd, result_we
    );

    modport cpu_issue (
        output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        input  issue_ready, issue_accept, issue_writeback
    );
    modport cpu_commit (
        output commit_valid, commit_id, commit_kill
    );
    modport cpu_result (
        output result_ready,
        input  result_valid, result_id, result_data, result_rd, result_we
    );
endinterface

// File: rtl/xif_mac_seq_mul.sv
// Iterative radix-2 shift-add multiplier, low 32 bits, one partial product per cycle.
module xif_mac_seq_mul
    import xif_mac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic        done_q, done_d;

    // The first partial product is folded into the start cycle so done lands MUL_CYCLES after start.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        done_d   = done_q;
        if (abort_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (start_i) begin
            prod_d   = b_i[0] ? a_i : 32'd0;
            mcand_d  = a_i << 1;
            mplier_d = b_i >> 1;
            cnt_d    = 6'(MUL_CYCLES - 1);
            done_d   = 1'b0;
        end else if (cnt_q != 6'd0) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 6'd1;
            done_d   = (cnt_q == 6'd1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule

// File: rtl/xif_mac_coprocessor.sv
// CORE-V-XIF multiply-accumulate coprocessor on custom-0 (MAC / CLR / RDA).
// Define XIF_MAC_FAST_MUL_EN for a single-cycle multiplier instead of xif_mac_seq_mul.
module xif_mac_coprocessor
    import xif_mac_pkg::*;
#(
    parameter int         X_ID_WIDTH = 4,
    parameter logic [6:0] OPCODE     = OPCODE_CUSTOM0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    if_xif.coproc_issue  xif_issue_if,
    if_xif.coproc_commit xif_commit_if,
    if_xif.coproc_result xif_result_if,
    output logic [31:0]  acc_o
);

    mac_state_e            state_q, state_d;
    mac_op_e               op_q, op_d, iss_op;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]            rd_q, rd_d;
    logic                  committed_q, committed_d;
    logic                  done_q, done_d;
    logic [31:0]           acc_q, acc_d;
    logic [31:0]           res_data_q, res_data_d;

    logic [31:0] instr, rs0, rs1;
    logic        dec_valid, issue_hs, issue_acc;
    logic        commit_at_issue, kill_at_issue, commit_hit, kill_hit, commit_now;
    logic        iss_done, done;
    logic [31:0] iss_data, busy_data, product;

    assign instr  = xif_issue_if.issue_instr;
    assign rs0    = xif_issue_if.issue_rs[0];
    assign rs1    = xif_issue_if.issue_rs[1];
    assign iss_op = mac_op_e'(instr[14:12]);

    assign dec_valid = is_mac_instr(instr, OPCODE);
    assign xif_issue_if.issue_ready     = (state_q == IDLE) && !rst_i &&
                                          ((instr[14:12] != 3'b000) || (&xif_issue_if.issue_rs_valid));
    assign xif_issue_if.issue_accept    = xif_issue_if.issue_valid && dec_valid;
    assign xif_issue_if.issue_writeback = xif_issue_if.issue_valid && dec_valid;

    assign issue_hs  = xif_issue_if.issue_valid && xif_issue_if.issue_ready;
    assign issue_acc = issue_hs && dec_valid;

    assign commit_at_issue = xif_commit_if.commit_valid && (xif_commit_if.commit_id == xif_issue_if.issue_id);
    assign kill_at_issue   = commit_at_issue && xif_commit_if.commit_kill;
    assign commit_hit      = xif_commit_if.commit_valid && (xif_commit_if.commit_id == id_q);
    assign kill_hit        = commit_hit && xif_commit_if.commit_kill;

`ifdef XIF_MAC_FAST_MUL_EN
    logic [31:0] rs0_q, rs0_d, rs1_q, rs1_d;

    assign rs0_d    = issue_acc ? rs0 : rs0_q;
    assign rs1_d    = issue_acc ? rs1 : rs1_q;
    assign iss_done = 1'b1;
    assign iss_data = (iss_op == MAC) ? acc_q + rs0 * rs1 : acc_q;
    assign product  = rs0_q * rs1_q;
    assign done     = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rs0_q <= '0;
            rs1_q <= '0;
        end else begin
            rs0_q <= rs0_d;
            rs1_q <= rs1_d;
        end
    end
`else
    logic mul_start, mul_abort, mul_done;
    logic [31:0] mul_product;

    // The multiply starts speculatively at issue; only a kill stops it.
    assign mul_start = issue_acc && (iss_op == MAC) && !kill_at_issue;
    assign mul_abort = (state_q == BUSY) && kill_hit;
    assign iss_done  = (iss_op != MAC);
    assign iss_data  = acc_q;
    assign product   = mul_product;
    assign done      = done_q || mul_done;

    xif_mac_seq_mul u_seq_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .abort_i   (mul_abort),
        .a_i       (rs0),
        .b_i       (rs1),
        .done_o    (mul_done),
        .product_o (mul_product)
    );
`endif

    assign busy_data  = (op_q == MAC) ? acc_q + product : acc_q;
    assign commit_now = committed_q || commit_hit;

    // An instruction that is committed and finished at issue skips BUSY so the result lands at c+1.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        rd_d        = rd_q;
        committed_d = committed_q;
        done_d      = done_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: begin
                if (issue_acc && !kill_at_issue) begin
                    op_d        = iss_op;
                    id_d        = xif_issue_if.issue_id;
                    rd_d        = instr[11:7];
                    committed_d = commit_at_issue;
                    done_d      = iss_done;
                    if (iss_done && commit_at_issue) begin
                        state_d    = RESULT;
                        res_data_d = iss_data;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (kill_hit) begin
                    state_d     = IDLE;
                    committed_d = 1'b0;
                    done_d      = 1'b0;
                end else begin
                    committed_d = commit_now;
                    if (commit_now && done) begin
                        state_d    = RESULT;
                        res_data_d = busy_data;
                    end
                end
            end
            RESULT: begin
                if (xif_result_if.result_ready) begin
                    state_d     = IDLE;
                    committed_d = 1'b0;
                    done_d      = 1'b0;
                    case (op_q)
                        MAC:     acc_d = res_data_q;
                        CLR:     acc_d = 32'd0;
                        default: acc_d = acc_q;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= MAC;
            id_q        <= '0;
            rd_q        <= '0;
            committed_q <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rd_q        <= rd_d;
            committed_q <= committed_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
        end
    end

    assign xif_result_if.result_valid = (state_q == RESULT);
    assign xif_result_if.result_id    = id_q;
    assign xif_result_if.result_rd    = rd_q;
    assign xif_result_if.result_data  = res_data_q;
    assign xif_result_if.result_we    = (rd_q != 5'd0);
    assign acc_o                      = acc_q;

endmodule

// File: tb/tb_xif_mac_coprocessor.sv
// Self-checking bench for xif_mac_coprocessor: directed vector table, corner sequences and random ops.
module tb_xif_mac_coprocessor;

`ifdef XIF_MAC_FAST_MUL_EN
    localparam int L_MAC = 0;
`else
    localparam int L_MAC = 32;
`endif

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [3:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        int          cdelay;
        bit          kill;
        bit          stray;
        int          hold;
        logic [31:0] expData;
        logic [31:0] expAcc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] accObs;
    int          cyc;
    int          checks;
    int          errors;
    logic [31:0] modelAcc;

    if_xif #(.X_ID_WIDTH(4)) xif ();

    xif_mac_coprocessor #(.X_ID_WIDTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .xif_issue_if  (xif),
        .xif_commit_if (xif),
        .xif_result_if (xif),
        .acc_o         (accObs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 10'd0, f3, rd, opc};
    endfunction

    // Architectural reference: what rd receives and what acc becomes after one op.
    function automatic void modelOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] data, output logic [31:0] accAfter);
        logic [31:0] prod;
        prod = a * b;
        case (f3)
            3'b000: begin data = modelAcc + prod; accAfter = data; end
            3'b001: begin data = modelAcc;        accAfter = 32'd0; end
            default: begin data = modelAcc;       accAfter = modelAcc; end
        endcase
    endfunction

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    // Issue one instruction, commit/kill it at i+cdelay, then collect and retire its result.
    task automatic applyStimulus(input vec_t v);
        int          i;
        int          first;
        int          nValid;
        int          expFirst;
        int          lat;
        @(negedge clk);
        xif.issue_valid    = 1'b1;
        xif.issue_instr    = mkInstr(7'd0, v.f3, v.rd, 7'h0B);
        xif.issue_id       = v.id;
        xif.issue_rs[0]    = v.a;
        xif.issue_rs[1]    = v.b;
        xif.issue_rs_valid = 2'b11;
        if (v.cdelay == 0) begin
            xif.commit_valid = 1'b1;
            xif.commit_id    = v.id;
            xif.commit_kill  = v.kill;
        end
        #1;
        checkOutput({v.name, ".issue_ready"}, 32'(xif.issue_ready), 32'd1);
        checkOutput({v.name, ".accept"}, 32'(xif.issue_accept), 32'd1);
        i      = cyc;
        first  = -1;
        nValid = 0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            xif.issue_valid = 1'b0;
            if (cyc == i + v.cdelay) begin
                xif.commit_valid = 1'b1;
                xif.commit_id    = v.id;
                xif.commit_kill  = v.kill;
            end else if (v.stray && cyc == i + 1) begin
                xif.commit_valid = 1'b1;
                xif.commit_id    = v.id ^ 4'h1;
                xif.commit_kill  = 1'b1;
            end else begin
                xif.commit_valid = 1'b0;
                xif.commit_kill  = 1'b0;
            end
            #1;
            if (v.kill) begin
                if (cyc == i + v.cdelay)
                    checkOutput({v.name, ".ready_at_kill"}, 32'(xif.issue_ready), 32'd0);
                if (cyc == i + v.cdelay + 1)
                    checkOutput({v.name, ".ready_after_kill"}, 32'(xif.issue_ready), 32'd1);
                if (xif.result_valid) nValid++;
                if (cyc >= i + v.cdelay + 40) break;
            end else if (xif.result_valid) begin
                first = cyc;
                break;
            end
        end
        xif.commit_valid = 1'b0;
        xif.commit_kill  = 1'b0;
        if (v.kill) begin
            checkOutput({v.name, ".no_result"}, 32'(nValid), 32'd0);
            checkOutput({v.name, ".acc_kept"}, accObs, v.expAcc);
            return;
        end
        if (first < 0) begin
            checkOutput({v.name, ".result_timeout"}, 32'd0, 32'd1);
            return;
        end
        lat      = (v.f3 == 3'b000) ? L_MAC : 0;
        expFirst = ((v.cdelay > lat) ? i + v.cdelay : i + lat) + 1;
        checkOutput({v.name, ".latency"}, 32'(first - i), 32'(expFirst - i));
        checkOutput({v.name, ".data"}, xif.result_data, v.expData);
        checkOutput({v.name, ".rd"}, 32'(xif.result_rd), 32'(v.rd));
        checkOutput({v.name, ".id"}, 32'(xif.result_id), 32'(v.id));
        checkOutput({v.name, ".we"}, 32'(xif.result_we), 32'(v.rd != 5'd0));
        for (int h = 0; h < v.hold; h++) begin
            xif.issue_valid = 1'b1;
            xif.issue_instr = mkInstr(7'd0, 3'b010, 5'd1, 7'h0B);
            xif.issue_id    = v.id + 4'd1;
            #1;
            checkOutput({v.name, ".second_issue_refused"}, 32'(xif.issue_ready), 32'd0);
            @(negedge clk);
            #1;
            checkOutput({v.name, ".hold_valid"}, 32'(xif.result_valid), 32'd1);
            checkOutput({v.name, ".hold_data"}, xif.result_data, v.expData);
            checkOutput({v.name, ".hold_id_rd"}, {23'd0, xif.result_id, xif.result_rd},
                        {23'd0, v.id, v.rd});
        end
        xif.issue_valid  = 1'b0;
        xif.result_ready = 1'b1;
        @(negedge clk);
        xif.result_ready = 1'b0;
        #1;
        checkOutput({v.name, ".valid_dropped"}, 32'(xif.result_valid), 32'd0);
        checkOutput({v.name, ".acc"}, accObs, v.expAcc);
        checkOutput({v.name, ".ready_again"}, 32'(xif.issue_ready), 32'd1);
    endtask

    task automatic checkRejected(input string name, input logic [31:0] instr, input logic [1:0] rsv,
                                 input logic expReady);
        @(negedge clk);
        xif.issue_valid    = 1'b1;
        xif.issue_instr    = instr;
        xif.issue_id       = 4'd2;
        xif.issue_rs_valid = rsv;
        #1;
        checkOutput({name, ".ready"}, 32'(xif.issue_ready), 32'(expReady));
        if (rsv == 2'b11) begin
            checkOutput({name, ".accept"}, 32'(xif.issue_accept), 32'd0);
            checkOutput({name, ".writeback"}, 32'(xif.issue_writeback), 32'd0);
        end
        @(negedge clk);
        xif.issue_valid    = 1'b0;
        xif.issue_rs_valid = 2'b11;
        xif.issue_instr    = mkInstr(7'd0, 3'b010, 5'd1, 7'h0B);
        #1;
        checkOutput({name, ".stays_idle"}, 32'(xif.issue_ready), 32'd1);
        checkOutput({name, ".no_result"}, 32'(xif.result_valid), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t        rv;
        logic [31:0] d;
        logic [31:0] accNext;
        int          nValid;

        checks = 0;
        errors = 0;
        modelAcc = 32'd0;
        rst = 1'b1;
        xif.issue_valid    = 1'b0;
        xif.issue_instr    = 32'd0;
        xif.issue_id       = 4'd0;
        xif.issue_rs[0]    = 32'd0;
        xif.issue_rs[1]    = 32'd0;
        xif.issue_rs_valid = 2'b11;
        xif.commit_valid   = 1'b0;
        xif.commit_id      = 4'd0;
        xif.commit_kill    = 1'b0;
        xif.result_ready   = 1'b0;

        //           name         f3      rd     id     a              b              c   k  s  hold data           acc
        vecs[0] = '{"mac3x5",    3'b000, 5'd5,  4'd1,  32'd3,         32'd5,         0,  0, 0, 0, 32'd15,        32'd15};
        vecs[1] = '{"mac7x6_c40",3'b000, 5'd9,  4'd2,  32'd7,         32'd6,         40, 0, 0, 0, 32'd57,        32'd57};
        vecs[2] = '{"mac_kill",  3'b000, 5'd4,  4'd3,  32'd100,       32'd100,       10, 1, 0, 0, 32'd0,         32'd57};
        vecs[3] = '{"rda_hold5", 3'b010, 5'd3,  4'd4,  32'd0,         32'd0,         0,  0, 0, 5, 32'd57,        32'd57};
        vecs[4] = '{"mac_to_max",3'b000, 5'd0,  4'd5,  32'hFFFF_FFC6, 32'd1,         3,  0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{"clr_full",  3'b001, 5'd7,  4'd6,  32'd0,         32'd0,         6,  0, 1, 0, 32'hFFFF_FFFF, 32'd0};
        vecs[6] = '{"rda_zero",  3'b010, 5'd8,  4'd7,  32'd0,         32'd0,         2,  0, 0, 0, 32'd0,         32'd0};
        vecs[7] = '{"mac_max",   3'b000, 5'd1,  4'd8,  32'hFFFF_FFFF, 32'd1,         0,  0, 0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[8] = '{"mac_wrap",  3'b000, 5'd2,  4'd9,  32'd1,         32'd1,         1,  0, 0, 0, 32'd0,         32'd0};
        vecs[9] = '{"mac_trunc", 3'b000, 5'd31, 4'd15, 32'h0001_0000, 32'h0001_0003, 0,  0, 0, 0, 32'h0003_0000, 32'h0003_0000};

        repeat (3) @(negedge clk);
        xif.issue_valid = 1'b1;
        xif.issue_instr = mkInstr(7'd0, 3'b010, 5'd1, 7'h0B);
        #1;
        checkOutput("reset.issue_ready", 32'(xif.issue_ready), 32'd0);
        checkOutput("reset.result_valid", 32'(xif.result_valid), 32'd0);
        checkOutput("reset.result_data", xif.result_data, 32'd0);
        checkOutput("reset.acc", accObs, 32'd0);
        xif.issue_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset.issue_ready", 32'(xif.issue_ready), 32'd1);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k]);
            modelAcc = vecs[k].expAcc;
        end

        checkRejected("enc_f3_011", mkInstr(7'd0, 3'b011, 5'd1, 7'h0B), 2'b11, 1'b1);
        checkRejected("enc_f7_set", mkInstr(7'd1, 3'b000, 5'd1, 7'h0B), 2'b11, 1'b1);
        checkRejected("enc_opcode", mkInstr(7'd0, 3'b000, 5'd1, 7'h33), 2'b11, 1'b1);
        checkRejected("mac_rs_valid_01", mkInstr(7'd0, 3'b000, 5'd1, 7'h0B), 2'b01, 1'b0);

        for (int r = 0; r < 20; r++) begin
            rv.name   = $sformatf("rand%0d", r);
            rv.f3     = 3'($urandom_range(0, 2));
            rv.rd     = 5'($urandom);
            rv.id     = 4'($urandom);
            rv.a      = $urandom;
            rv.b      = $urandom;
            rv.cdelay = $urandom_range(0, 40);
            rv.kill   = ($urandom_range(0, 7) == 0);
            if (rv.kill && rv.cdelay == 0) rv.cdelay = 1;
            rv.stray  = (rv.cdelay > 2) && !rv.kill && ($urandom_range(0, 1) == 1);
            rv.hold   = $urandom_range(0, 3);
            modelOp(rv.f3, rv.a, rv.b, d, accNext);
            rv.expData = d;
            rv.expAcc  = rv.kill ? modelAcc : accNext;
            applyStimulus(rv);
            modelAcc = rv.expAcc;
        end

        rv = '{"pre_reset_mac", 3'b000, 5'd6, 4'd3, 32'd11, 32'd13, 0, 0, 0, 0, 32'd0, 32'd0};
        modelOp(rv.f3, rv.a, rv.b, d, accNext);
        rv.expData = d;
        rv.expAcc  = accNext;
        applyStimulus(rv);
        modelAcc = rv.expAcc;

        @(negedge clk);
        xif.issue_valid  = 1'b1;
        xif.issue_instr  = mkInstr(7'd0, 3'b000, 5'd6, 7'h0B);
        xif.issue_id     = 4'd4;
        xif.issue_rs[0]  = 32'd2;
        xif.issue_rs[1]  = 32'd2;
        xif.commit_valid = 1'b1;
        xif.commit_id    = 4'd4;
        xif.commit_kill  = 1'b0;
        @(negedge clk);
        xif.issue_valid  = 1'b0;
        xif.commit_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset.acc", accObs, 32'd0);
        checkOutput("midreset.issue_ready", 32'(xif.issue_ready), 32'd0);
        checkOutput("midreset.result_valid", 32'(xif.result_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelAcc = 32'd0;
        nValid = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (xif.result_valid) nValid++;
        end
        checkOutput("midreset.no_result", 32'(nValid), 32'd0);

        rv = '{"post_reset_rda", 3'b010, 5'd5, 4'd6, 32'd0, 32'd0, 1, 0, 0, 0, 32'd0, 32'd0};
        modelOp(rv.f3, rv.a, rv.b, d, accNext);
        rv.expData = d;
        rv.expAcc  = accNext;
        applyStimulus(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
